// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer with a third flop for edge detection
module sync_edge #(
    parameter logic INIT = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q <= INIT;
            s2_q <= INIT;
            s3_q <= INIT;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~s3_q;
    assign fall_o  = ~s2_q & s3_q;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode 0 slave, oversampled by the system clock,
// with a show-ahead transmit source and a pulsed receive sink.
module spi_slave #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] in,
    output logic         get,
    input  logic         empty,
    output logic [W-1:0] out,
    output logic         put,
    input  logic         spi_cs_n,
    input  logic         spi_clock,
    input  logic         spi_mosi,
    output logic         spi_miso
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    logic cs_lvl, cs_rise, cs_fall;
    logic sck_lvl, sck_rise, sck_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic unused_edges;

    sync_edge #(.INIT(1'b1)) u_cs (
        .clock  (clock),
        .reset  (reset),
        .d_i    (spi_cs_n),
        .level_o(cs_lvl),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    sync_edge #(.INIT(1'b0)) u_sck (
        .clock  (clock),
        .reset  (reset),
        .d_i    (spi_clock),
        .level_o(sck_lvl),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    sync_edge #(.INIT(1'b0)) u_mosi (
        .clock  (clock),
        .reset  (reset),
        .d_i    (spi_mosi),
        .level_o(mosi_lvl),
        .rise_o (mosi_rise),
        .fall_o (mosi_fall)
    );

    assign unused_edges = ^{cs_rise, sck_lvl, mosi_rise, mosi_fall};

    state_t         state_q, state_d;
    logic [W-1:0]   tx_q, tx_d;
    logic [W-1:0]   rx_q, rx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d;
    logic [W-1:0]   out_q, out_d;
    logic           put_q, put_d;
    logic           load;

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        out_d   = out_q;
        put_d   = 1'b0;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                // Clock edges seen in the same cycle as select are ignored here.
                if (cs_fall) begin
                    state_d = SHIFT;
                    load    = 1'b1;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (sck_rise) begin
                    rx_d = {rx_q[W-2:0], mosi_lvl};
                    if (cnt_q == CW'(W - 1)) begin
                        cnt_d  = '0;
                        out_d  = rx_d;
                        put_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                // Falling edge after a finished word fetches the next word.
                if (sck_fall) begin
                    if (done_q) begin
                        load   = 1'b1;
                        done_d = 1'b0;
                    end else begin
                        tx_d = {tx_q[W-2:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (cs_lvl) begin
            state_d = IDLE;
            load    = 1'b0;
            cnt_d   = '0;
            rx_d    = '0;
            done_d  = 1'b0;
            put_d   = 1'b0;
            out_d   = out_q;
        end

        if (load) begin
            tx_d = empty ? '0 : in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            out_q   <= '0;
            put_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            out_q   <= out_d;
            put_q   <= put_d;
        end
    end

    assign get      = load & ~empty & ~reset;
    assign out      = out_q;
    assign put      = put_q;
    assign spi_miso = (state_q == SHIFT) ? tx_q[W-1] : 1'b0;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed bench with a word-level model of the SPI slave
module tb_spi_slave;

    localparam int W    = 8;
    localparam int HALF = 6;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] in_r = '0;
    logic         empty_r = 1'b1;
    logic         get;
    logic [W-1:0] out;
    logic         put;
    logic         spi_cs_n = 1'b1;
    logic         spi_clock = 1'b0;
    logic         spi_mosi = 1'b0;
    logic         spi_miso;

    int checks = 0;
    int errors = 0;
    int get_cnt = 0;
    int put_cnt = 0;
    int pops = 0;
    int cs_hi_cnt = 0;
    logic [W-1:0] src_q[$];
    logic [W-1:0] exp_put_q[$];
    logic [W-1:0] last_put = '0;

    spi_slave #(.W(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .in       (in_r),
        .get      (get),
        .empty    (empty_r),
        .out      (out),
        .put      (put),
        .spi_cs_n (spi_cs_n),
        .spi_clock(spi_clock),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Show-ahead source: consume the head one edge after each observed get.
    always @(posedge clock) begin
        #1;
        while (pops < get_cnt) begin
            if (src_q.size() > 0) void'(src_q.pop_front());
            pops++;
        end
        empty_r = (src_q.size() == 0);
        in_r    = (src_q.size() > 0) ? src_q[0] : '0;
    end

    // Per-cycle monitor away from the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (put) begin
                put_cnt++;
                last_put = out;
                if (exp_put_q.size() == 0) begin
                    chk("unexpected_put", {24'd0, out}, 32'hFFFF_FFFF);
                end else begin
                    chk("put_word", {24'd0, out}, {24'd0, exp_put_q.pop_front()});
                end
            end
            if (get) begin
                get_cnt++;
                chk("get_while_empty", {31'd0, empty_r}, 32'd0);
            end
            cs_hi_cnt = spi_cs_n ? cs_hi_cnt + 1 : 0;
            if (cs_hi_cnt > 6) chk("miso_idle", {31'd0, spi_miso}, 32'd0);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic sel();
        spi_cs_n = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic desel();
        wait_cyc(HALF);
        spi_cs_n = 1'b1;
        wait_cyc(10);
    endtask

    task automatic bits(input logic [31:0] data, input int n, output logic [31:0] got);
        got = '0;
        for (int i = 0; i < n; i++) begin
            spi_mosi = data[n-1-i];
            wait_cyc(HALF);
            spi_clock = 1'b1;
            got = {got[30:0], spi_miso};
            wait_cyc(HALF);
            spi_clock = 1'b0;
        end
    endtask

    // Master sees the source words in order, zero-filled once the source runs dry.
    function automatic logic [31:0] model_miso(input logic [W-1:0] s[$], input int n);
        logic [31:0]  r = '0;
        logic [W-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = ((i / W) < s.size()) ? s[i / W] : '0;
            r = {r[30:0], w[W-1 - (i % W)]};
        end
        return r;
    endfunction

    // One fetch at select plus one after every completed word, limited by supply.
    function automatic int model_gets(input int supply, input int n);
        int loads = n / W + 1;
        return (supply < loads) ? supply : loads;
    endfunction

    task automatic run_xact(input string name, input logic [31:0] data, input int n,
                            input logic [31:0] lit_miso);
        logic [W-1:0] snap[$];
        logic [31:0]  got, exp_miso;
        logic [31:0]  tmp;
        int           g0, exp_g;
        snap = src_q;
        exp_miso = model_miso(snap, n);
        exp_g = model_gets(snap.size(), n);
        for (int k = 0; k < n / W; k++) begin
            tmp = data >> (n - W * (k + 1));
            exp_put_q.push_back(tmp[W-1:0]);
        end
        g0 = get_cnt;
        sel();
        bits(data, n, got);
        desel();
        chk({name, "_miso_model"}, got, exp_miso);
        chk({name, "_miso_literal"}, got, lit_miso);
        chk({name, "_gets"}, get_cnt - g0, exp_g);
        chk({name, "_puts_done"}, exp_put_q.size(), 0);
        exp_put_q.delete();
    endtask

    task automatic load_src(input logic [31:0] words, input int nw);
        logic [31:0] t;
        src_q.delete();
        for (int k = 0; k < nw; k++) begin
            t = words >> (W * (nw - 1 - k));
            src_q.push_back(t[W-1:0]);
        end
        wait_cyc(2);
    endtask

    initial begin
        logic [31:0] got;
        int          p0;

        wait_cyc(4);
        reset = 1'b0;
        wait_cyc(1);
        chk("reset_get", {31'd0, get}, 0);
        chk("reset_put", {31'd0, put}, 0);
        chk("reset_miso", {31'd0, spi_miso}, 0);
        chk("reset_out", {24'd0, out}, 0);
        wait_cyc(10);

        load_src(0, 0);
        run_xact("rx_a5", 32'hA5, 8, 32'h00);
        chk("rx_a5_out", {24'd0, out}, 32'hA5);

        load_src(32'h3C, 1);
        run_xact("tx_3c", 32'h5A, 8, 32'h3C);

        load_src(0, 0);
        run_xact("empty_src", 32'h96, 8, 32'h00);
        chk("empty_src_put", {24'd0, last_put}, 32'h96);

        load_src(32'h5678, 2);
        run_xact("b2b", 32'h1234, 16, 32'h5678);
        chk("b2b_last_out", {24'd0, out}, 32'h34);

        load_src(32'hA1B2C3, 3);
        run_xact("three", 32'h0F_F0_69, 24, 32'hA1B2C3);

        load_src(0, 0);
        p0 = put_cnt;
        sel();
        bits(32'h6, 3, got);
        desel();
        chk("partial_no_put", put_cnt - p0, 0);
        chk("partial_out_held", {24'd0, out}, 32'h69);
        run_xact("after_partial", 32'hC3, 8, 32'h00);
        chk("after_partial_out", {24'd0, out}, 32'hC3);

        load_src(0, 0);
        p0 = put_cnt;
        sel();
        bits(32'hF, 4, got);
        reset = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(2);
        chk("rst_mid_miso", {31'd0, spi_miso}, 0);
        chk("rst_mid_out", {24'd0, out}, 0);
        chk("rst_mid_no_put", put_cnt - p0, 0);
        desel();
        load_src(32'hE7, 1);
        run_xact("after_reset", 32'h81, 8, 32'hE7);
        chk("after_reset_out", {24'd0, out}, 32'h81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter W, default 8, word width in bits (W >= 2).
REQ-002 clock  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 in  input  W  next word to transmit; valid while empty is low (show-ahead source).
REQ-005 get  output  1  one-clock pulse; consumes in; asserted only while empty is low.
REQ-006 empty  input  1  high when the source has no word.
REQ-007 out  output  W  last word received, MSB first.
REQ-008 put  output  1  one-clock pulse; out is valid in the same cycle.
REQ-009 spi_cs_n  input  1  chip select, active low, asynchronous to clock.
REQ-010 spi_clock  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clock.
REQ-011 spi_mosi  input  1  serial data from master.
REQ-012 spi_miso  output  1  serial data to master.

Function
REQ-013 spi_cs_n, spi_clock and spi_mosi SHALL each pass a two-flop synchronizer; edges SHALL be detected by a third flop comparing with the second flop.
REQ-014 Legal operation SHALL require each spi_clock half-period of at least 4 clock cycles; behaviour below that limit is undefined.
REQ-015 States SHALL be IDLE (deselected) and SHIFT (selected); a synced spi_cs_n falling edge SHALL move IDLE->SHIFT; a synced spi_cs_n high SHALL force IDLE from any state.
REQ-016 On IDLE->SHIFT the block SHALL load the transmit register from in and pulse get if empty is low, or load all zeros without get if empty is high; the bit counter SHALL clear.
REQ-017 In SHIFT, on each synced spi_clock rising edge, spi_mosi (synced) SHALL shift into the receive register LSB side and the bit counter SHALL increment modulo W.
REQ-018 When the rising edge completes bit W-1, out SHALL take the full received word and put SHALL pulse high for exactly the following clock cycle.
REQ-019 On each synced spi_clock falling edge in SHIFT, the transmit register SHALL shift left one bit, except on the falling edge after a completed word, when it SHALL reload per REQ-016 rules (back-to-back words).
REQ-020 spi_miso SHALL equal the transmit register MSB in SHIFT and 0 in IDLE.
REQ-021 spi_cs_n rising mid-word SHALL discard the partial word: no put, counter cleared, out unchanged.
REQ-022 get SHALL pulse at most once per word; put and get in the same cycle are legal.
REQ-023 A spi_clock edge coincident with the spi_cs_n falling edge detection SHALL be ignored.

Reset
REQ-024 On reset the state SHALL be IDLE; get, put, spi_miso = 0; out = 0; shift registers and counter = 0; synchronizer flops = spi_cs_n 1, others 0.
REQ-025 Reset mid-word SHALL abandon the word without put or get; after reset, a new spi_cs_n falling edge is required to start.

Structure
REQ-026 No shared package; W is the only parameter, the state encoding stays local.
REQ-027 One sub-module is natural: a reusable synchronizer-plus-edge-detector, sync_edge (outputs level, rise, fall), instantiated three times.
REQ-028 The file SHALL sit beside the SPI master under bitbang/ as spi-slave.v.

Verification
REQ-029 Master sends 0xA5 with spi_cs_n low -> single put with out = 0xA5.
REQ-030 in = 0x3C, empty = 0, select -> one get; master receives 0x3C on spi_miso.
REQ-031 empty = 1 during select -> no get; master receives 0x00; the received word still produces put.
REQ-032 Back-to-back words 0x12, 0x34 under one select, source holds 0x56, 0x78 -> two puts (0x12, 0x34), two gets, and the master receives 0x56 then 0x78.
REQ-033 spi_cs_n raised after 3 bits, then full word 0xC3 -> no put for the partial word, then put with 0xC3.
REQ-034 reset pulsed after 4 bits of 0xFF -> no put; spi_miso = 0; the next full selection transfers 0x81 correctly.
